// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer with a 2-entry prefetch FIFO, redirect handling and a shared ROM port.
// Define IMEM_DBG_PORT_EN to enable round-robin arbitration of the debug read port.
module imem_fetch_ctrl #(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 8,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] imem_a,
  input  logic [DWIDTH-1:0] imem_rd,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DWIDTH-1:0] inst_data,
  output logic [AWIDTH-1:0] inst_pc,
  input  logic              dbg_req,
  input  logic [AWIDTH-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic [DWIDTH-1:0] dbg_rdata,
  output logic              dbg_rvalid
);

  logic [AWIDTH-1:0] fetch_pc_q;
  logic [AWIDTH-1:0] fifo_pc_q   [2];
  logic [DWIDTH-1:0] fifo_data_q [2];
  logic [1:0]        count_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;

  logic              pop;
  logic              fetch_elig;
  logic              fetch_own;
  logic              dbg_own;
  logic [AWIDTH-1:0] dbg_a;

  assign inst_valid = !rst && (count_q != 2'd0);
  assign inst_data  = fifo_data_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];
  assign pop        = inst_valid && inst_ready;

  // A full FIFO may still fetch when the head drains in the same cycle.
  assign fetch_elig = !rst && !redirect_valid && ((count_q != 2'd2) || pop);

`ifdef IMEM_DBG_PORT_EN
  logic              last_owner_q;  // 1: debug owned the last granted cycle
  logic              dbg_req_eff;
  logic [DWIDTH-1:0] dbg_rdata_q;
  logic              dbg_rvalid_q;
  logic              unused_bits;

  assign dbg_req_eff = dbg_req && !rst;
  assign fetch_own   = fetch_elig && (!dbg_req_eff || last_owner_q);
  assign dbg_own     = dbg_req_eff && (!fetch_elig || !last_owner_q);
  assign dbg_a       = {dbg_addr[AWIDTH-1:2], 2'b00};
  assign dbg_gnt     = dbg_own;
  assign dbg_rdata   = dbg_rdata_q;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign unused_bits = ^{dbg_addr[1:0], redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= 1'b1;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      if (fetch_own) begin
        last_owner_q <= 1'b0;
      end else if (dbg_own) begin
        last_owner_q <= 1'b1;
      end
      dbg_rvalid_q <= dbg_own;
      if (dbg_own) begin
        dbg_rdata_q <= imem_rd;
      end
    end
  end
`else
  logic unused_bits;

  assign fetch_own   = fetch_elig;
  assign dbg_own     = 1'b0;
  assign dbg_a       = '0;
  assign dbg_gnt     = 1'b0;
  assign dbg_rdata   = '0;
  assign dbg_rvalid  = 1'b0;
  assign unused_bits = ^{dbg_req, dbg_addr, redirect_pc[1:0]};
`endif

  assign imem_a = rst ? RESET_PC : (dbg_own ? dbg_a : fetch_pc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else if (redirect_valid) begin
      // Flush wins over any pop presented in the same cycle.
      fetch_pc_q <= {redirect_pc[AWIDTH-1:2], 2'b00};
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      if (fetch_own) begin
        fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
        fifo_data_q[wr_ptr_q] <= imem_rd;
        wr_ptr_q              <= ~wr_ptr_q;
        fetch_pc_q            <= fetch_pc_q + AWIDTH'(4);
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(fetch_own) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: vector table for fetch/stall/redirect/wrap plus
// hand-written debug-port sequences for whichever build is compiled.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        dbg_req = 1'b0;
  logic [7:0]  dbg_addr = 8'h00;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_gnt        (dbg_gnt),
    .dbg_rdata      (dbg_rdata),
    .dbg_rvalid     (dbg_rvalid)
  );

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h0030_0093;
      8'h04:   return 32'h0090_0113;
      8'h08:   return 32'h0020_8133;
      default: return {16'hA5A5, 8'h00, a};
    endcase
  endfunction

  assign imem_rd = rom_word(imem_a);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         rdy;
    bit         redir;
    logic [7:0] rpc;
    bit         ev;
    logic [7:0] epc;
    logic [7:0] ea;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic prev_gnt;
    logic exp_gnt;
    logic exp_v;

    // rst rdy redir rpc | valid pc imem_a
    vecs.push_back('{1, 1, 0, 8'h00, 0, 8'h00, 8'h00});
    vecs.push_back('{1, 1, 0, 8'h00, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h00, 8'h04});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h04, 8'h08});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h08, 8'h0C});
    // stall after reset: FIFO fills with 0x00/0x04, fetch parks at 0x08
    vecs.push_back('{1, 0, 0, 8'h00, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 0, 0, 8'h00, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 8'h00, 8'h04});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 8'h00, 8'h08});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 8'h00, 8'h08});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 8'h00, 8'h08});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h00, 8'h08});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h04, 8'h0C});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h08, 8'h10});
    // full FIFO, then redirect to 0x0E with ready high
    vecs.push_back('{0, 0, 0, 8'h00, 1, 8'h0C, 8'h14});
    vecs.push_back('{0, 1, 1, 8'h0E, 1, 8'h0C, 8'h14});
    vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 8'h0C});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h0C, 8'h10});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h10, 8'h14});
    // redirect near the top of the address space to exercise wrap
    vecs.push_back('{0, 1, 1, 8'hF8, 1, 8'h14, 8'h18});
    vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 8'hF8});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'hF8, 8'hFC});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'hFC, 8'h00});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h00, 8'h04});
    // redirect during reset is ignored
    vecs.push_back('{1, 1, 1, 8'h40, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 1, 0, 8'h00, 0, 8'h00, 8'h00});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 8'h00, 8'h04});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      inst_ready     = vecs[i].rdy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      dbg_req        = 1'b0;
      #1;
      chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d inst_pc", i), 32'(inst_pc), 32'(vecs[i].epc));
        chk($sformatf("v%0d inst_data", i), inst_data, rom_word(vecs[i].epc));
      end
      chk($sformatf("v%0d imem_a", i), 32'(imem_a), 32'(vecs[i].ea));
      chk($sformatf("v%0d dbg_gnt", i), 32'(dbg_gnt), 32'd0);
      chk($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'd0);
      chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, 32'd0);
    end

    // Debug request held through reset and afterwards, misaligned address.
    @(negedge clk);
    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    dbg_req        = 1'b1;
    dbg_addr       = 8'h05;
    #1;
    chk("dbg gnt in reset", 32'(dbg_gnt), 32'd0);
    chk("imem_a in reset", 32'(imem_a), 32'h00);

`ifdef IMEM_DBG_PORT_EN
    prev_gnt = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      rst            = 1'b0;
      redirect_valid = (k == 8);
      redirect_pc    = 8'h20;
      #1;
      if (k < 8)       exp_gnt = (k % 2) == 1;
      else if (k == 8) exp_gnt = 1'b1;
      else             exp_gnt = (k == 10);
      chk($sformatf("dbg k%0d gnt", k), 32'(dbg_gnt), 32'(exp_gnt));
      chk($sformatf("dbg k%0d rvalid", k), 32'(dbg_rvalid), 32'(prev_gnt));
      if (prev_gnt) chk($sformatf("dbg k%0d rdata", k), dbg_rdata, 32'h0090_0113);
      if (exp_gnt) chk($sformatf("dbg k%0d imem_a", k), 32'(imem_a), 32'h04);
      else chk($sformatf("dbg k%0d fetch imem_a", k), 32'(imem_a),
               (k < 8) ? 32'((k / 2) * 4) : ((k == 9) ? 32'h20 : 32'h24));
      if (k < 8) begin
        exp_v = (k % 2) == 1;
        chk($sformatf("dbg k%0d inst_valid", k), 32'(inst_valid), 32'(exp_v));
        if (exp_v) begin
          chk($sformatf("dbg k%0d inst_pc", k), 32'(inst_pc), 32'((k - 1) * 2));
          chk($sformatf("dbg k%0d inst_data", k), inst_data, rom_word(8'((k - 1) * 2)));
        end
      end
      prev_gnt = exp_gnt;
    end
`else
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk($sformatf("nodbg k%0d gnt", k), 32'(dbg_gnt), 32'd0);
      chk($sformatf("nodbg k%0d rvalid", k), 32'(dbg_rvalid), 32'd0);
      chk($sformatf("nodbg k%0d rdata", k), dbg_rdata, 32'd0);
      chk($sformatf("nodbg k%0d imem_a", k), 32'(imem_a), 32'(k * 4));
      exp_v = (k >= 1);
      chk($sformatf("nodbg k%0d inst_valid", k), 32'(inst_valid), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("nodbg k%0d inst_pc", k), 32'(inst_pc), 32'((k - 1) * 4));
        chk($sformatf("nodbg k%0d inst_data", k), inst_data, rom_word(8'((k - 1) * 4)));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
